// File: rtl/remote_pkg.sv
// Shared definitions for the remote-player link: frame layout, parser states
// and the bit positions of the level/start byte.
package remote_pkg;

  localparam logic [7:0] FRAME_HDR   = 8'hA5;
  localparam int         FRAME_LEN   = 6;
  localparam int         PAYLOAD_LEN = FRAME_LEN - 2;
  localparam int         SLOT_W      = $clog2(PAYLOAD_LEN);
  localparam int         LEVEL_MSB   = 7;
  localparam int         START_BIT   = 5;

  typedef enum logic [1:0] {
    HDR,
    PAYLOAD,
    CHK
  } rx_state_t;

endpackage

// File: rtl/timeout_counter.sv
// Idle/watchdog counter: expired is high once LIMIT-1 enabled cycles have
// accumulated since the last clear, and stays high until cleared.
module timeout_counter #(
  parameter int unsigned LIMIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned   W    = $clog2(LIMIT + 1);
  localparam logic [W-1:0]  LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/remote_player_rx.sv
// Parses 6-byte remote-player frames from the UART and publishes position,
// level and start flag on good checksums. REMOTE_LINK_TIMEOUT_EN adds a link watchdog.
module remote_player_rx
  import remote_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 65_000_000,
  parameter int unsigned BYTE_TIMEOUT = CLK_HZ / 1000,
  parameter int unsigned LINK_TIMEOUT = CLK_HZ / 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] x_value_rm,
  output logic [11:0] y_value_rm,
  output logic [1:0]  level_rm,
  output logic        sync_signal,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        link_up
);

  if (BYTE_TIMEOUT < 2 || LINK_TIMEOUT < 2) begin : g_bad_limits
    $error("remote_player_rx: timeouts must be at least 2 cycles");
  end

  rx_state_t         state, state_eff, state_next;
  logic [2:0]        idx, idx_next;
  logic [7:0]        acc, acc_next;
  logic [7:0]        shadow [PAYLOAD_LEN];
  logic [SLOT_W-1:0] slot;
  logic              shadow_we, good_frame, bad_frame;
  logic              byte_expired, byte_clear, byte_enable;

  assign byte_clear  = (state == HDR) || rx_valid;
  assign byte_enable = (state != HDR);

  timeout_counter #(.LIMIT(BYTE_TIMEOUT)) u_byte_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (byte_clear),
    .enable  (byte_enable),
    .expired (byte_expired)
  );

  assign slot = SLOT_W'(idx - 3'd1);

  // An expiring gap forces HDR before this cycle's byte is looked at.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_eff  = byte_expired ? HDR : state;
    state_next = state_eff;
    idx_next   = idx;
    acc_next   = acc;
    shadow_we  = 1'b0;
    good_frame = 1'b0;
    bad_frame  = 1'b0;
    unique case (state_eff)
      HDR: begin
        if (rx_valid && rx_data == FRAME_HDR) begin
          state_next = PAYLOAD;
          acc_next   = '0;
          idx_next   = 3'd1;
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          shadow_we = 1'b1;
          acc_next  = acc ^ rx_data;
          if (idx == 3'(PAYLOAD_LEN)) state_next = CHK;
          else                        idx_next   = idx + 3'd1;
        end
      end
      CHK: begin
        if (rx_valid) begin
          good_frame = (rx_data == acc);
          bad_frame  = (rx_data != acc);
          state_next = HDR;
        end
      end
      default: state_next = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HDR;
      idx   <= '0;
      acc   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      acc   <= acc_next;
    end
  end

  // NOTE: the shadow bytes are deliberately not reset; they are only read after
  // a full frame has rewritten all of them.
  always_ff @(posedge clk) begin
    if (shadow_we) shadow[slot] <= rx_data;
  end

`ifdef REMOTE_LINK_TIMEOUT_EN
  logic link_expired;

  timeout_counter #(.LIMIT(LINK_TIMEOUT)) u_link_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (good_frame),
    .enable  (link_up),
    .expired (link_expired)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      x_value_rm  <= '0;
      y_value_rm  <= '0;
      level_rm    <= '0;
      sync_signal <= 1'b0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      link_up     <= 1'b0;
    end else begin
      frame_ok  <= good_frame;
      frame_err <= bad_frame;
`ifdef REMOTE_LINK_TIMEOUT_EN
      if (link_expired) begin
        link_up     <= 1'b0;
        sync_signal <= 1'b0;
      end
`endif
      if (good_frame) begin
        x_value_rm <= {shadow[0], shadow[1][7:4]};
        y_value_rm <= {shadow[1][3:0], shadow[2]};
        level_rm   <= shadow[3][LEVEL_MSB -: 2];
        link_up    <= 1'b1;
        if (shadow[3][START_BIT]) sync_signal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_remote_player_rx.sv
// Scoreboard bench for remote_player_rx: each completed frame pushes its
// expected result; the monitor pops and compares on every frame_ok/frame_err.
module tb_remote_player_rx;

  localparam int unsigned BT = 100;
  localparam int unsigned LT = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [11:0] x_value_rm, y_value_rm;
  logic [1:0]  level_rm;
  logic        sync_signal, frame_ok, frame_err, link_up;

  always #5 clk = ~clk;

  remote_player_rx #(
    .CLK_HZ       (65_000_000),
    .BYTE_TIMEOUT (BT),
    .LINK_TIMEOUT (LT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .x_value_rm  (x_value_rm),
    .y_value_rm  (y_value_rm),
    .level_rm    (level_rm),
    .sync_signal (sync_signal),
    .frame_ok    (frame_ok),
    .frame_err   (frame_err),
    .link_up     (link_up)
  );

  typedef struct {
    logic        ok;
    logic        err;
    logic [11:0] x;
    logic [11:0] y;
    logic [1:0]  lvl;
    logic        sync;
    logic        link;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  bit hold_en  = 1'b1;

  // pred_*: state after all frames driven so far; cur_*: after frames observed.
  logic [11:0] pred_x = '0, pred_y = '0, cur_x = '0, cur_y = '0;
  logic [1:0]  pred_lvl = '0, cur_lvl = '0;
  logic        pred_sync = 1'b0, pred_link = 1'b0, cur_sync = 1'b0, cur_link = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst) begin
      if (frame_ok || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {frame_ok, frame_err}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          check("frame_ok",  frame_ok,    e.ok);
          check("frame_err", frame_err,   e.err);
          check("x",         x_value_rm,  e.x);
          check("y",         y_value_rm,  e.y);
          check("level",     level_rm,    e.lvl);
          check("sync",      sync_signal, e.sync);
          check("link",      link_up,     e.link);
          check("latency",   cyc,         e.cyc);
          cur_x = e.x; cur_y = e.y; cur_lvl = e.lvl; cur_sync = e.sync; cur_link = e.link;
        end
      end else if (hold_en) begin
        check("hold", {x_value_rm, y_value_rm, level_rm, sync_signal, link_up},
                      {cur_x, cur_y, cur_lvl, cur_sync, cur_link});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called right after the checksum byte was sampled: result is due this cycle.
  task automatic push_expect(input logic bad, input logic [11:0] x, input logic [11:0] y,
                             input logic [1:0] lvl, input logic st);
    exp_t e;
    if (!bad) begin
      pred_x = x; pred_y = y; pred_lvl = lvl;
      pred_sync = pred_sync | st;
      pred_link = 1'b1;
    end
    e.ok = !bad; e.err = bad;
    e.x = pred_x; e.y = pred_y; e.lvl = pred_lvl; e.sync = pred_sync; e.link = pred_link;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [11:0] x, input logic [11:0] y, input logic [1:0] lvl,
                            input logic st, input logic bad, input int gap);
    logic [7:0] b [6];
    b[0] = 8'hA5;
    b[1] = x[11:4];
    b[2] = {x[3:0], y[11:8]};
    b[3] = y[7:0];
    b[4] = {lvl, st, 5'b0};
    b[5] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ (bad ? 8'h03 : 8'h00);
    for (int i = 0; i < 6; i++) begin
      send_byte(b[i]);
      if (i == 1 && gap > 0) idle(gap);
    end
    push_expect(bad, x, y, lvl, st);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_x",    x_value_rm,  12'h000);
    check("rst_y",    y_value_rm,  12'h000);
    check("rst_lvl",  level_rm,    2'b00);
    check("rst_sync", sync_signal, 1'b0);
    check("rst_ok",   frame_ok,    1'b0);
    check("rst_err",  frame_err,   1'b0);
    check("rst_link", link_up,     1'b0);
    pred_x = '0; pred_y = '0; pred_lvl = '0; pred_sync = 1'b0; pred_link = 1'b0;
    cur_x = '0; cur_y = '0; cur_lvl = '0; cur_sync = 1'b0; cur_link = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] good1 [6];
    logic [7:0] bad1  [6];
    // Checksum of 7D,2C,80,C0 is 8'h11.
    good1 = '{8'hA5, 8'h7D, 8'h2C, 8'h80, 8'hC0, 8'h11};
    bad1  = '{8'hA5, 8'h7D, 8'h2C, 8'h80, 8'hC0, 8'h32};

    repeat (3) @(posedge clk);
    #1;
    do_reset();
    mon_en = 1'b1;
    idle(2);

    for (int i = 0; i < 6; i++) send_byte(good1[i]);
    push_expect(1'b0, 12'h7D2, 12'hC80, 2'b11, 1'b0);
    idle(3);

    for (int i = 0; i < 6; i++) send_byte(bad1[i]);
    push_expect(1'b1, 12'h000, 12'h000, 2'b00, 1'b0);
    idle(3);

    // Fragment abandoned by a full byte timeout, then a clean frame.
    send_byte(8'hA5);
    send_byte(8'h7D);
    idle(BT);
    send_frame(12'h010, 12'h123, 2'b10, 1'b0, 1'b0, 0);
    idle(3);

    // Longest gap that does not expire.
    send_frame(12'h456, 12'h789, 2'b01, 1'b0, 1'b0, BT - 2);
    idle(3);

    // Byte arriving on the expiry cycle is a header candidate: a new frame starts there.
    send_byte(8'hA5);
    send_byte(8'h33);
    idle(BT - 1);
    send_frame(12'h9AB, 12'hCDE, 2'b11, 1'b0, 1'b0, 0);
    idle(3);

    // Start flag is sticky across a later start=0 frame.
    send_frame(12'h111, 12'h222, 2'b01, 1'b1, 1'b0, 0);
    send_frame(12'h333, 12'h444, 2'b00, 1'b0, 1'b0, 0);
    idle(3);

    // Junk before the header, and A5 as payload data.
    send_byte(8'h11);
    send_byte(8'h22);
    send_frame(12'hA53, 12'h5A1, 2'b10, 1'b0, 1'b0, 0);
    idle(2);

    // Back-to-back frames, bad one in the middle.
    send_frame(12'hFFF, 12'h000, 2'b11, 1'b0, 1'b0, 0);
    send_frame(12'h001, 12'hFFF, 2'b00, 1'b0, 1'b1, 0);
    send_frame(12'h800, 12'h801, 2'b01, 1'b1, 1'b0, 0);
    idle(3);

`ifdef REMOTE_LINK_TIMEOUT_EN
    idle(5);
    hold_en = 1'b0;
    idle(LT - 30);
    check("link_before_timeout", link_up, 1'b1);
    idle(40);
    check("link_after_timeout", link_up, 1'b0);
    check("sync_after_timeout", sync_signal, 1'b0);
    check("x_after_timeout", x_value_rm, pred_x);
    check("lvl_after_timeout", level_rm, pred_lvl);
    pred_link = 1'b0; pred_sync = 1'b0; cur_link = 1'b0; cur_sync = 1'b0;
    hold_en = 1'b1;
    send_frame(12'h0F0, 12'h00F, 2'b10, 1'b0, 1'b0, 0);
    idle(3);
`else
    idle(LT + 40);
    check("link_sticky", link_up, 1'b1);
    check("sync_sticky", sync_signal, 1'b1);
`endif

    // Reset in the middle of a frame, then a fresh frame.
    send_byte(8'hA5);
    send_byte(8'h7D);
    send_byte(8'h2C);
    do_reset();
    idle(2);
    send_frame(12'h5C3, 12'h3C5, 2'b01, 1'b0, 1'b0, 0);
    idle(10);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
